// File: rtl/ro_meas_pkg.sv
// rtl/ro_meas_pkg.sv - shared state type and defaults for the ring-oscillator measurement block
package ro_meas_pkg;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WIN_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } ro_meas_state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - synchronizer and rising-edge detector for the asynchronous RO output
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= ro_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - enables one RO, lets it settle, counts its edges over a programmable window
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WIN_W         = DEF_WIN_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Sel,
  input  logic [WIN_W-1:0] i_Window,
  input  logic             i_RO_out,
  output logic             o_RO_Enable,
  output logic             o_RO_Sel,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Overflow
);

  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);

  ro_meas_state_t   state, next_state;
  logic [WIN_W-1:0] dcnt_q;
  logic [WIN_W-1:0] win_m1_q;
  logic [CNT_W-1:0] edge_cnt_q, cnt_next;
  logic             ovf_q, ovf_next;
  logic             rise;
  logic             start_acc;
  logic             last;
  logic             busy_d, enable_d, valid_d;

  ro_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (i_Clk),
    .rst_n(i_Rst_n),
    .ro_in(i_RO_out),
    .rise (rise)
  );

  assign start_acc = (state == IDLE) && i_Start;
  assign last      = (dcnt_q == '0);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_Start) next_state = SETTLE;
      SETTLE:  if (last)    next_state = COUNT;
      COUNT:   if (last)    next_state = DONE;
      DONE:                 next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // Enable drops together with busy on the edge that leaves DONE.
  always_comb begin
    busy_d   = (next_state != IDLE);
    enable_d = busy_d;
    valid_d  = (next_state == DONE);
  end

  // One down-counter times both phases: settle length first, then the latched window.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dcnt_q   <= '0;
      win_m1_q <= '0;
      o_RO_Sel <= 1'b0;
    end else if (start_acc) begin
      dcnt_q   <= SETTLE_LOAD;
      win_m1_q <= (i_Window == '0) ? '0 : i_Window - 1'b1;
      o_RO_Sel <= i_Sel;
    end else if (state == SETTLE) begin
      dcnt_q <= last ? win_m1_q : dcnt_q - 1'b1;
    end else if (state == COUNT && !last) begin
      dcnt_q <= dcnt_q - 1'b1;
    end
  end

  always_comb begin
    cnt_next = edge_cnt_q;
    ovf_next = ovf_q;
    if (state == COUNT && rise) begin
      if (&edge_cnt_q) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (start_acc) begin
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      edge_cnt_q <= cnt_next;
      ovf_q      <= ovf_next;
    end
  end

  // Result is captured from cnt_next so an edge seen on the final COUNT clock is kept.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Busy      <= 1'b0;
      o_RO_Enable <= 1'b0;
      o_Valid     <= 1'b0;
      o_Count     <= '0;
      o_Overflow  <= 1'b0;
    end else begin
      o_Busy      <= busy_d;
      o_RO_Enable <= enable_d;
      o_Valid     <= valid_d;
      if (valid_d) begin
        o_Count    <= cnt_next;
        o_Overflow <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb/tb_ro_freq_counter.sv - randomized self-checking bench for ro_freq_counter
`timescale 1ns/100ps
module tb_ro_freq_counter;

  localparam int S = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel   = 1'b0;
  logic [15:0] window = '0;
  logic        ro    = 1'b0;
  logic        ro_en, ro_sel, busy, valid, overflow;
  logic [15:0] count;

  logic        start8 = 1'b0;
  logic [15:0] window8 = '0;
  logic        ro8 = 1'b0;
  logic        ro_en8, ro_sel8, busy8, valid8, overflow8;
  logic [7:0]  count8;

  int ro_half = 20;
  int n_cmp = 0;
  int n_bad = 0;

  ro_freq_counter dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Sel(sel), .i_Window(window),
    .i_RO_out(ro), .o_RO_Enable(ro_en), .o_RO_Sel(ro_sel), .o_Busy(busy),
    .o_Valid(valid), .o_Count(count), .o_Overflow(overflow)
  );

  ro_freq_counter #(.CNT_W(8)) dut8 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start8), .i_Sel(1'b0), .i_Window(window8),
    .i_RO_out(ro8), .o_RO_Enable(ro_en8), .o_RO_Sel(ro_sel8), .o_Busy(busy8),
    .o_Valid(valid8), .o_Count(count8), .o_Overflow(overflow8)
  );

  always #2.5 clk = ~clk;

  // RO edges land on whole ns, clock edges on half ns, so sampling never races.
  always begin
    #(ro_half);
    ro = ~ro;
  end

  initial begin
    #1;
    forever #5 ro8 = ~ro8;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected edges: window time divided by RO period, within the given tolerance.
  task automatic chk_count(input string tag, input int cnt, input int win, input int half, input int tol);
    int weff, exp_milli, diff;
    weff      = (win == 0) ? 1 : win;
    exp_milli = (weff * 5 * 1000) / (2 * half);
    diff      = cnt * 1000 - exp_milli;
    chk($sformatf("%s w=%0d p=%0d got=%0d exp_milli=%0d", tag, weff, 2 * half, cnt, exp_milli),
        (diff <= tol * 1000 && diff >= -tol * 1000) ? 1 : 0, 1);
  endtask

  // Called at a negedge; start is seen by the very next rising edge.
  task automatic run_meas(input logic s, input int win, input int repulse_at,
                          output int cnt, output int ovf);
    int weff, n, lat, nv;
    weff   = (win == 0) ? 1 : win;
    start  = 1'b1;
    sel    = s;
    window = win[15:0];
    @(negedge clk);
    start = 1'b0;
    sel   = ~s;
    chk("busy_on", busy, 1);
    chk("enable_on", ro_en, 1);
    n = 0; lat = -1; nv = 0; cnt = 0; ovf = 0;
    while (n < weff + S + 40) begin
      if (valid) begin
        nv++;
        if (lat < 0) begin
          lat = n;
          cnt = int'(count);
          ovf = int'(overflow);
        end
      end
      if (lat >= 0 && n > lat) break;
      start = (n == repulse_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("valid_latency", lat, weff + S);
    chk("valid_pulses", nv, 1);
    chk("busy_off", busy, 0);
    chk("enable_off", ro_en, 0);
    chk("ro_sel_held", ro_sel, s);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, ovf, nv, lat, win, half;
    logic s;

    repeat (3) @(negedge clk);
    chk("rst_enable", ro_en, 0);
    chk("rst_sel", ro_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_meas(1'b0, 800, -1, cnt, ovf);
    chk_count("nominal_count", cnt, 800, 20, 1);
    chk("nominal_ovf", ovf, 0);

    run_meas(1'b1, 800, 100, cnt, ovf);
    chk_count("repulse_count", cnt, 800, 20, 1);

    run_meas(1'b0, 0, -1, cnt, ovf);
    chk("win0_count_le1", (cnt <= 1) ? 1 : 0, 1);

    run_meas(1'b1, 800, -1, cnt, ovf);
    chk_count("pre_reset_count", cnt, 800, 20, 1);

    start = 1'b1; sel = 1'b1; window = 16'd800;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    #1 rst_n = 1'b0;
    #0.5;
    chk("midrst_enable", ro_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_sel", ro_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (S + 820) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("no_valid_after_reset", nv, 0);
    chk("idle_after_reset", busy, 0);

    run_meas(1'b0, 800, -1, cnt, ovf);
    chk_count("post_reset_count", cnt, 800, 20, 1);

    for (int k = 0; k < 6; k++) begin
      half = $urandom_range(10, 40);
      win  = $urandom_range(1, 300);
      s    = 1'($urandom_range(0, 1));
      ro_half = half;
      repeat (20) @(negedge clk);
      run_meas(s, win, -1, cnt, ovf);
      chk_count("rand_count", cnt, win, half, 2);
      chk("rand_ovf", ovf, 0);
    end

    start8  = 1'b1;
    window8 = 16'd4000;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int n = 0; n < 4100 && lat < 0; n++) begin
      if (valid8) lat = n;
      else @(negedge clk);
    end
    chk("sat_latency", lat, 4000 + S);
    chk("sat_count", count8, 255);
    chk("sat_overflow", overflow8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
